addsub_cla_pipe: RTL

- Pipelined, parametrised two's-complement adder/subtractor.
- Operand width W is split into NB = W/BW carry-lookahead blocks. One block is resolved per pipeline stage, and the block carry is registered into the next stage.
- Throughput is one operation per clock, with a valid/ready handshake on both input and output.
- Sits in the ALU datapath as the wide-operand successor to the single-cycle 4-bit CLA add/sub. Adds pipelining, backpressure, and N/Z flags.

---
 rtl/addsub_cla_pipe.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/addsub_cla_pipe.sv
// Pipelined two's-complement adder/subtractor built from carry-lookahead blocks.
// The operand is split into NB = W/BW blocks. Each pipeline stage resolves one
// block and registers the block carry into the next stage, so the latency is NB.
// A valid/ready handshake on both sides stalls the whole pipe as a unit.
// Optional build macro: ADDSUB_CLA_SAT_EN. It clamps the result to the signed
// limit on overflow. The flags n and z follow the clamped s, while c and v stay raw.
module addsub_cla_pipe #(
   parameter int W  = 16,
   parameter int BW = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         m,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] s,
   output logic         c,
   output logic         v,
   output logic         n,
   output logic         z
);

   localparam int NB = W / BW;
   // Stages before the last still need the operand bits they have not processed yet.
   localparam int NA = (NB > 1) ? NB - 1 : 1;

   if ((W % BW) != 0 || W < 2) begin : g_param_check
      $error("addsub_cla_pipe: W must be a multiple of BW and at least 2");
   end

   logic                 adv;
   logic [W-1:0]         bx_in;

   logic [NB-1:0]        vld_q, vld_d;
   logic [NB-1:0][W-1:0] s_q, s_d;
   logic [NB-1:0]        cy_q, cy_d;
   logic                 v_q, v_d;
   logic [NA-1:0][W-1:0] a_q, a_d;
   logic [NA-1:0][W-1:0] bx_q, bx_d;

   logic [W-1:0]         src_a, src_bx, src_s;
   logic                 src_c, src_v;
   logic [BW+1:0]        blk;

   // One lookahead block: every carry is expanded directly from the block carry-in.
   // Returned bits: {carry into the block MSB, block carry out, sum bits}.
   function automatic logic [BW+1:0] cla_block(input logic [BW-1:0] ab,
                                                input logic [BW-1:0] bb,
                                                input logic          cin);
      logic [BW-1:0] p, g, sum;
      logic [BW:0]   cr;
      logic          term, pp;
      p     = ab ^ bb;
      g     = ab & bb;
      cr    = '0;
      cr[0] = cin;
      for (int i = 0; i < BW; i++) begin
         term = g[i];
         pp   = p[i];
         for (int j = i - 1; j >= 0; j--) begin
            term = term | (pp & g[j]);
            pp   = pp & p[j];
         end
         cr[i+1] = term | (pp & cin);
      end
      sum = p ^ cr[BW-1:0];
      return {cr[BW-1], cr[BW], sum};
   endfunction

   assign adv      = !vld_q[NB-1] || out_ready;
   assign in_ready = adv;

   // Next contents of every stage, assuming the pipe advances this cycle.
   always_comb begin
      vld_d  = '0;
      s_d    = '0;
      cy_d   = '0;
      v_d    = 1'b0;
      a_d    = '0;
      bx_d   = '0;
      src_a  = '0;
      src_bx = '0;
      src_s  = '0;
      src_c  = 1'b0;
      src_v  = 1'b0;
      blk    = '0;
      bx_in  = b ^ {W{m}};
      for (int k = 0; k < NB; k++) begin
         if (k == 0) begin
            src_a  = a;
            src_bx = bx_in;
            src_s  = '0;
            src_c  = m;
            src_v  = in_valid;
         end else begin
            src_a  = a_q[k-1];
            src_bx = bx_q[k-1];
            src_s  = s_q[k-1];
            src_c  = cy_q[k-1];
            src_v  = vld_q[k-1];
         end
         blk                  = cla_block(src_a[k*BW +: BW], src_bx[k*BW +: BW], src_c);
         vld_d[k]             = src_v;
         s_d[k]               = src_s;
         s_d[k][k*BW +: BW]   = blk[BW-1:0];
         cy_d[k]              = blk[BW];
         if (k < NB - 1) begin
            a_d[k]  = src_a;
            bx_d[k] = src_bx;
         end else begin
            v_d = blk[BW] ^ blk[BW+1];
`ifdef ADDSUB_CLA_SAT_EN
            // On overflow a and bx share a sign, so the sign of a picks the limit.
            if (v_d) begin
               s_d[k] = src_a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
            end
`endif
         end
      end
   end

   // Stage registers: a reset clears everything, and a stall holds every stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
         s_q   <= '0;
         cy_q  <= '0;
         v_q   <= 1'b0;
         a_q   <= '0;
         bx_q  <= '0;
      end else if (adv) begin
         vld_q <= vld_d;
         s_q   <= s_d;
         cy_q  <= cy_d;
         v_q   <= v_d;
         a_q   <= a_d;
         bx_q  <= bx_d;
      end
   end

   assign out_valid = vld_q[NB-1];
   assign s         = s_q[NB-1];
   assign c         = cy_q[NB-1];
   assign v         = v_q;
   assign n         = s_q[NB-1][W-1];
   assign z         = (s_q[NB-1] == '0);

endmodule
